alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one ALU instance between two requesters (e.g. the execute stage and an address/branch helper unit) with valid/ready handshakes on both sides. Each cycle it grants at most one requester, drives the ALU operands and opcode, and registers the ALU result into a one-entry response buffer for the granted requester. Round-robin priority prevents starvation. The block sits between the requesters and the shared ALU, with the ALU as an external combinational instance.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width (0 add, 1 sll, 2 xor, 3 srl, 4 sra, 5 or, 6 and, 7 sub, 8 pass A, 9 pass B, others add)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  DATA_W  requester 0 operands
- req0_op  in  OP_W  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, requester 1
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 consumes result
- resp0_data  out  DATA_W  result for requester 0
- resp1_valid, resp1_ready, resp1_data  same as above, requester 1
- alu_a, alu_b  out  DATA_W  operands to the shared ALU
- alu_op  out  OP_W  opcode to the shared ALU
- alu_out  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)

## Operation
- Eligibility: reqN is eligible when reqN_valid=1 and its response slot is free, i.e. respN_valid=0, or respN_valid=1 and respN_ready=1 in the same cycle.
- Grant (combinational):
  - one eligible requester: it is granted;
  - both eligible: the requester other than last_grant is granted;
  - none eligible: no grant.
- reqN_ready = grantN. Only one reqN_ready may be high in a cycle.
- ALU drive:
  - with a grant: alu_a/alu_b/alu_op = the granted requester's a/b/op;
  - without a grant: alu_a=0, alu_b=0, alu_op=0.
- On the clock edge with grantN: respN_data <= alu_out, respN_valid <= 1, last_grant <= N.
- On the clock edge with respN_valid=1, respN_ready=1 and no grantN: respN_valid <= 0. respN_data holds its value.
- Drain and refill of the same slot in one cycle is a back-to-back transfer: respN_valid stays 1 and respN_data takes the new result.
- last_grant changes only on a grant.
- A requester may hold reqN_valid with changing operands. Only the operands present in the granted cycle are used.
- Opcode is passed through unmodified. Width and shift semantics belong to the ALU.

## Timing
- Reset values (async assert, sync release by clk): req0_ready=0, req1_ready=0, resp0_valid=0, resp1_valid=0, resp0_data=0, resp1_data=0, last_grant=1 (requester 0 wins the first tie), alu_a/alu_b/alu_op=0.
- Latency: request accepted in cycle T gives respN_valid=1 with the result in cycle T+1.
- Throughput: one operation per cycle total. One per cycle per requester when it is the only active requester and drains its response every cycle.
- Both requesters continuously active with responses drained every cycle: grants strictly alternate 0,1,0,1… after reset (0 first).
- Response backpressure: while respN_valid=1 and respN_ready=0, reqN_ready=0. The other requester may take every cycle.
- Reset mid-operation: pending responses are discarded. No response appears after reset release without a new grant.
- req*_ready and alu_* are combinational from req*_valid, resp*_valid, resp*_ready and last_grant. There is no combinational path from alu_out to any output.

## Test plan
- Single requester: after reset, req0 = (a=5, b=3, op=0), resp0_ready=1 → req0_ready=1 in cycle T; resp0_valid=1 with resp0_data=8 in T+1.
- Tie and round-robin: both valid every cycle, req0 = (7, 2, op 7), req1 = (0xF0, 0x0F, op 5), responses always ready → grants 0,1,0,1; resp0_data=5 and resp1_data=0xFF alternating.
- Backpressure: resp1_ready=0 with resp1_valid=1 and req1_valid=1 → req1_ready stays 0 and resp1_data is stable. req0 is granted each cycle. Raising resp1_ready gives req1 a grant in the same cycle.
- Back-to-back on one slot: req0 issues sll (1, 4) then sra (0x80000000, 4) with resp0_ready=1 → resp0_data = 0x10 then 0xF8000000 on consecutive cycles; resp0_valid never drops.
- Idle: no valid requests → alu_a=0, alu_b=0, alu_op=0, both ready=0, last_grant unchanged.
- Reset mid-flight: assert rst_n=0 one cycle after a grant → resp0_valid and resp1_valid drop immediately (async). After release, the first tie goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two valid/ready
// requesters with round-robin priority and a one-entry result buffer each.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out
);

  logic              last_grant_r;
  logic              resp0_valid_r;
  logic              resp1_valid_r;
  logic [DATA_W-1:0] resp0_data_r;
  logic [DATA_W-1:0] resp1_data_r;
  logic              elig0_s;
  logic              elig1_s;
  logic              grant0_s;
  logic              grant1_s;

  // Eligibility and round-robin grant; a tie goes to the requester not granted last.
  always_comb begin
    elig0_s  = req0_valid && (!resp0_valid_r || resp0_ready);
    elig1_s  = req1_valid && (!resp1_valid_r || resp1_ready);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  // Route the granted requester's operands to the shared ALU, zeros when idle.
  always_comb begin
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    alu_op = {OP_W{1'b0}};
    if (grant0_s) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (grant1_s) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end else begin
      alu_a  = {DATA_W{1'b0}};
      alu_b  = {DATA_W{1'b0}};
      alu_op = {OP_W{1'b0}};
    end
  end

  // Round-robin pointer; moves only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Response slot 0: refill on grant (also covers drain+refill), else drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid_r <= 1'b0;
      resp0_data_r  <= {DATA_W{1'b0}};
    end else if (grant0_s) begin
      resp0_valid_r <= 1'b1;
      resp0_data_r  <= alu_out;
    end else if (resp0_valid_r && resp0_ready) begin
      resp0_valid_r <= 1'b0;
    end else begin
      resp0_valid_r <= resp0_valid_r;
    end
  end

  // Response slot 1: same policy as slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp1_valid_r <= 1'b0;
      resp1_data_r  <= {DATA_W{1'b0}};
    end else if (grant1_s) begin
      resp1_valid_r <= 1'b1;
      resp1_data_r  <= alu_out;
    end else if (resp1_valid_r && resp1_ready) begin
      resp1_valid_r <= 1'b0;
    end else begin
      resp1_valid_r <= resp1_valid_r;
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign resp0_valid = resp0_valid_r;
  assign resp1_valid = resp1_valid_r;
  assign resp0_data  = resp0_data_r;
  assign resp1_data  = resp1_data_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with hand-computed results; the bench also
// plays the external combinational ALU.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [DATA_W-1:0] resp0_data, resp1_data;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [OP_W-1:0]   alu_op;

  int tests_run = 0;
  int tests_failed = 0;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    case (alu_op)
      4'd1:    alu_out = alu_a << alu_b[4:0];
      4'd2:    alu_out = alu_a ^ alu_b;
      4'd3:    alu_out = alu_a >> alu_b[4:0];
      4'd4:    alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd5:    alu_out = alu_a | alu_b;
      4'd6:    alu_out = alu_a & alu_b;
      4'd7:    alu_out = alu_a - alu_b;
      4'd8:    alu_out = alu_a;
      4'd9:    alu_out = alu_b;
      default: alu_out = alu_a + alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #12;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    check("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    check("rst_resp0_data", resp0_data, 32'd0);
    check("rst_resp1_data", resp1_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    tick;

    // single requester: 5 + 3
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'd0;
    settle;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("single_alu_a", alu_a, 32'd5);
    check("single_alu_b", alu_b, 32'd3);
    tick;
    check("single_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    check("single_resp0_data", resp0_data, 32'd8);
    req0_valid = 1'b0;
    tick;
    check("drain_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    check("drain_resp0_hold", resp0_data, 32'd8);

    // back-to-back on slot 0: sll then sra
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd4; req0_op = 4'd1;
    tick;
    check("b2b_sll_valid", {31'd0, resp0_valid}, 32'd1);
    check("b2b_sll_data", resp0_data, 32'h0000_0010);
    req0_a = 32'h8000_0000; req0_b = 32'd4; req0_op = 4'd4;
    settle;
    check("b2b_refill_ready", {31'd0, req0_ready}, 32'd1);
    tick;
    check("b2b_sra_valid", {31'd0, resp0_valid}, 32'd1);
    check("b2b_sra_data", resp0_data, 32'hF800_0000);
    req0_valid = 1'b0;
    tick;

    // backpressure on slot 1: fill it first (3 + 4 = 7)
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'd0;
    tick;
    check("bp_fill_data", resp1_data, 32'd7);
    req1_a = 32'd10; req1_b = 32'd1; req1_op = 4'd7;
    req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd2; req0_op = 4'd2;
    for (int k = 0; k < 3; k++) begin
      settle;
      check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("bp_alu_a", alu_a, 32'd6);
      tick;
      check("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
      check("bp_resp1_stable", resp1_data, 32'd7);
      check("bp_resp0_data", resp0_data, 32'd4);
    end
    resp1_ready = 1'b1;
    settle;
    check("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("bp_release_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("bp_release_alu_a", alu_a, 32'd10);
    tick;
    check("bp_release_resp1", resp1_data, 32'd9);
    check("bp_resp0_drained", {31'd0, resp0_valid}, 32'd0);

    // idle: ALU zeroed, no ready, pointer stays on requester 1
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd7; req1_op = 4'd5;
    tick;
    tick;
    check("idle_alu_a", alu_a, 32'd0);
    check("idle_alu_b", alu_b, 32'd0);
    check("idle_alu_op", {28'd0, alu_op}, 32'd0);
    check("idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // tie and round-robin: 7-2=5 for req0, 0xF0|0x0F=0xFF for req1
    req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd2;    req0_op = 4'd7;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 4'd5;
    for (int k = 0; k < 4; k++) begin
      settle;
      check("rr_req0_ready", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_req1_ready", {31'd0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick;
      if (k % 2 == 0) check("rr_resp0_data", resp0_data, 32'd5);
      else            check("rr_resp1_data", resp1_data, 32'hFF);
    end

    // reset one cycle after a grant
    tick;
    check("mid_pre_valid", {31'd0, resp0_valid}, 32'd1);
    rst_n = 1'b0;
    settle;
    check("mid_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    check("mid_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    check("mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("mid_alu_a", alu_a, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick;
    check("post_rst_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    settle;
    check("post_rst_tie_req0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_tie_req1", {31'd0, req1_ready}, 32'd0);
    tick;
    check("post_rst_resp0_data", resp0_data, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
